// File: rtl/dlx_mem_pkg.sv
// Shared types and encodings for the DLX memory-access sequencer.
package dlx_mem_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ST_LD,
    WR,
    RD,
    RD_OUT,
    DONE,
    ERR
  } state_t;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  localparam int TIMEOUT_DEF = 15;

  typedef struct packed {
    logic       busy;
    logic       done;
    logic       err;
    logic       mem_read;
    logic       mem_write;
    logic       mdr_load;
    logic       mdr_oe;
    logic       mdr_src;
    logic [3:0] byte_en;
  } ctrl_out_t;

endpackage

// File: rtl/dlx_mem_be_dec.sv
// Big-endian byte-lane decode from access size and address low bits.
module dlx_mem_be_dec
  import dlx_mem_pkg::*;
(
  input  logic [1:0] size,
  input  logic [1:0] addr_lo,
  output logic [3:0] byte_en,
  output logic       misaligned
);

  // misaligned also flags the reserved size, so callers see one reject bit.
  always_comb begin
    byte_en    = 4'b0000;
    misaligned = 1'b0;
    case (size)
      SZ_BYTE: byte_en = 4'b1000 >> addr_lo;
      SZ_HALF: begin
        byte_en    = addr_lo[1] ? 4'b0011 : 4'b1100;
        misaligned = addr_lo[0];
      end
      SZ_WORD: begin
        byte_en    = 4'b1111;
        misaligned = |addr_lo;
      end
      default: misaligned = 1'b1;
    endcase
  end

endmodule

// File: rtl/dlx_mem_ctrl.sv
// Load/store sequencer: orders MDR capture, memory strobes and S2 drive,
// with alignment check and a bounded wait for mem_rdy.
module dlx_mem_ctrl
  import dlx_mem_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int CW      = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req,
  input  logic       we,
  input  logic [1:0] size,
  input  logic [1:0] addr_lo,
  input  logic       mem_rdy,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       MDRload,
  output logic       MDRoeS2,
  output logic       mdr_src,
  output logic [3:0] byte_en
);

  localparam logic [CW-1:0] LAST_WAIT = CW'(TIMEOUT - 1);

  state_t        state;
  logic [CW-1:0] wait_cnt;
  logic [3:0]    be_q;
  logic [3:0]    be_dec;
  logic          misaligned;
  ctrl_out_t     o;

  dlx_mem_be_dec u_be_dec (
    .size      (size),
    .addr_lo   (addr_lo),
    .byte_en   (be_dec),
    .misaligned(misaligned)
  );

  // Moore outputs for a state, loaded into o alongside the state register.
  function automatic ctrl_out_t outs_of(state_t s, logic [3:0] be);
    ctrl_out_t r;
    r      = '0;
    r.busy = (s != IDLE);
    case (s)
      ST_LD: begin
        r.mdr_load = 1'b1;
        r.mdr_src  = 1'b1;
      end
      WR: begin
        r.mem_write = 1'b1;
        r.byte_en   = be;
      end
      RD: begin
        r.mem_read = 1'b1;
        r.byte_en  = be;
      end
      RD_OUT:  r.mdr_oe = 1'b1;
      DONE:    r.done   = 1'b1;
      ERR:     r.err    = 1'b1;
      default: r        = '0;
    endcase
    return r;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      wait_cnt <= '0;
      o        <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            be_q     <= be_dec;
            wait_cnt <= '0;
            if (misaligned) begin
              state <= ERR;
              o     <= outs_of(ERR, be_dec);
            end else if (we) begin
              state <= ST_LD;
              o     <= outs_of(ST_LD, be_dec);
            end else begin
              state <= RD;
              o     <= outs_of(RD, be_dec);
            end
          end
        end
        ST_LD: begin
          state <= WR;
          o     <= outs_of(WR, be_q);
        end
        WR: begin
          // mem_rdy is checked first so a last-chance completion is not aborted.
          if (mem_rdy) begin
            state <= DONE;
            o     <= outs_of(DONE, be_q);
          end else if (wait_cnt == LAST_WAIT) begin
            state <= ERR;
            o     <= outs_of(ERR, be_q);
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        RD: begin
          if (mem_rdy) begin
            state <= RD_OUT;
            o     <= outs_of(RD_OUT, be_q);
          end else if (wait_cnt == LAST_WAIT) begin
            state <= ERR;
            o     <= outs_of(ERR, be_q);
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        RD_OUT: begin
          state <= DONE;
          o     <= outs_of(DONE, be_q);
        end
        DONE, ERR: begin
          state <= IDLE;
          o     <= outs_of(IDLE, be_q);
        end
        default: begin
          state <= IDLE;
          o     <= '0;
        end
      endcase
    end
  end

  assign busy     = o.busy;
  assign done     = o.done;
  assign err      = o.err;
  assign MemRead  = o.mem_read;
  assign MemWrite = o.mem_write;
  assign MDRoeS2  = o.mdr_oe;
  assign mdr_src  = o.mdr_src;
  assign byte_en  = o.byte_en;
  // Load data is captured in the same cycle memory reports it valid.
  assign MDRload  = o.mdr_load | ((state == RD) & mem_rdy);

  always_ff @(posedge clk) begin
    if (!reset) begin
      assert ($onehot0({MemRead, MemWrite, MDRoeS2}));
    end
  end

endmodule
